alu_bist: RTL
=============

ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 SHALL have parameter CHECK_CARRY_LOGIC, default 1; 1 = carry_out expected 0 for AND/OR/XOR, 0 = carry ignored for those ops.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  begin self-test; sampled only in IDLE or DONE.
REQ-006 SHALL have port a_o  output  4  operand A driven to the ALU under test.
REQ-007 SHALL have port b_o  output  4  operand B driven to the ALU under test.
REQ-008 SHALL have port sel_o  output  2  opcode driven to ALU: 00 AND, 01 OR, 10 XOR, 11 ADD.
REQ-009 SHALL have port alu_out_i  input  4  ALU result.
REQ-010 SHALL have port alu_cout_i  input  1  ALU carry_out.
REQ-011 SHALL have port busy  output  1  test in progress (RUN or DRAIN).
REQ-012 SHALL have port done  output  1  test complete; level, held in DONE.
REQ-013 SHALL have port pass  output  1  valid with done; 1 iff err_count==0.
REQ-014 SHALL have port err_count  output  11  number of mismatching vectors (0..1024, no saturation needed).
REQ-015 SHALL have port first_fail_vld  output  1  at least one mismatch recorded.
REQ-016 SHALL have port first_fail_vec  output  10  index of first mismatching vector.

Function
REQ-017 SHALL implement FSM IDLE -> RUN -> DRAIN -> DONE; DONE -> RUN on start; no other transitions except reset.
REQ-018 SHALL, on start in IDLE/DONE, clear err_count, first_fail_vld, first_fail_vec and enter RUN next edge.
REQ-019 SHALL ignore start in RUN/DRAIN.
REQ-020 SHALL in RUN drive vector index i (10-bit counter, 0..1023) as {sel_o,a_o,b_o}=i from registered outputs, one vector per cycle.
REQ-021 SHALL compare ALU response for vector i at the edge ending the cycle in which i is driven (1-cycle check latency).
REQ-022 SHALL go RUN -> DRAIN after index 1023 is driven; DRAIN lasts one cycle, checks vector 1023, then DONE.
REQ-023 SHALL assert done exactly 1026 cycles after the edge sampling start; busy high for the 1025 cycles between.
REQ-024 SHALL compute expected result: AND a&b, OR a|b, XOR a^b (carry 0), ADD {carry,out}=a+b (5-bit).
REQ-025 SHALL flag mismatch on any out bit difference, or carry difference for ADD, or for logic ops when CHECK_CARRY_LOGIC=1.
REQ-026 SHALL on mismatch increment err_count; on first mismatch only, set first_fail_vld and capture index.
REQ-027 SHALL hold a_o/b_o/sel_o at last driven vector in DRAIN/DONE, and at 0 in IDLE.

Reset
REQ-028 SHALL on rst_n low, at any time including mid-RUN, immediately force state IDLE, counter 0, and all outputs 0.
REQ-029 SHALL require a fresh start after reset release; no resumption of an aborted run.

Structure
REQ-030 SHALL take opcode constants (SEL_AND/OR/XOR/ADD), vector count 1024, and index width 10 from shared package alu_pkg.
REQ-031 SHALL place expected-result computation in one combinational sub-module alu_bist_golden (a, b, sel -> exp_out, exp_cout).

Verification
REQ-032 SHALL cover: correct ALU model, start pulse -> done after 1026 cycles, pass=1, err_count=0, first_fail_vld=0.
REQ-033 SHALL cover: alu_out_i[0] stuck-at-0 -> err_count=512, first_fail_vec=0x011, pass=0.
REQ-034 SHALL cover: alu_cout_i stuck-at-1, CHECK_CARRY_LOGIC=1 -> err_count=904, first_fail_vec=0x000; with CHECK_CARRY_LOGIC=0 -> err_count=136, first_fail_vec=0x300.
REQ-035 SHALL cover: rst_n low 300 cycles into RUN -> all outputs 0 immediately, IDLE; new start -> full clean run, pass=1.
REQ-036 SHALL cover: start pulsed during RUN -> ignored, done still at cycle 1026; start in DONE -> counters cleared, new run.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU built-in self-test.
// The test vector index maps directly onto {sel, a, b}.
package alu_pkg;

  localparam int DATA_W  = 4;
  localparam int SEL_W   = 2;
  localparam int IDX_W   = 10;
  localparam int NUM_VEC = 1024;
  localparam int ERR_W   = 11;

  localparam logic [SEL_W-1:0] SEL_AND = 2'b00;
  localparam logic [SEL_W-1:0] SEL_OR  = 2'b01;
  localparam logic [SEL_W-1:0] SEL_XOR = 2'b10;
  localparam logic [SEL_W-1:0] SEL_ADD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } vec_t;

endpackage

// File: rtl/alu_bist_golden.sv
// Reference model of the ALU under test: expected result and carry for one vector.
// Logic ops never produce a carry.
module alu_bist_golden
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] exp_out,
  output logic              exp_cout
);

  always_comb begin
    exp_out  = '0;
    exp_cout = 1'b0;
    case (sel)
      SEL_AND: exp_out = a & b;
      SEL_OR:  exp_out = a | b;
      SEL_XOR: exp_out = a ^ b;
      SEL_ADD: {exp_cout, exp_out} = {1'b0, a} + {1'b0, b};
      default: exp_out = '0;
    endcase
  end

endmodule

// File: rtl/alu_bist.sv
// Exhaustive self-test sequencer for a 4-bit, 4-op ALU: walks all 1024 vectors,
// checks each response one cycle later and records error count and first failure.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | after reset, outputs 0, waiting for start
// ST_RUN   | stepping vector index 0..1023 onto a_o/b_o/sel_o
// ST_DRAIN | last vector on the bus, its response checked at end of cycle
// ST_DONE  | results held, last vector held, waiting for a new start
module alu_bist
  import alu_pkg::*;
#(
  parameter int CHECK_CARRY_LOGIC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [SEL_W-1:0]  sel_o,
  input  logic [DATA_W-1:0] alu_out_i,
  input  logic              alu_cout_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              first_fail_vld,
  output logic [IDX_W-1:0]  first_fail_vec
);

  bist_state_e       state_q, state_d;
  logic              start_q, start_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  vec_t              vec_q, vec_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              ff_vld_q, ff_vld_d;
  logic [IDX_W-1:0]  ff_vec_q, ff_vec_d;

  logic [DATA_W-1:0] exp_out;
  logic              exp_cout;
  logic              chk_carry;
  logic              mismatch;

  alu_bist_golden u_golden (
    .a        (vec_q.a),
    .b        (vec_q.b),
    .sel      (vec_q.sel),
    .exp_out  (exp_out),
    .exp_cout (exp_cout)
  );

  assign chk_carry = (vec_q.sel == SEL_ADD) || (CHECK_CARRY_LOGIC != 0);
  assign mismatch  = (alu_out_i != exp_out) || (chk_carry && (alu_cout_i != exp_cout));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    vec_d     = vec_q;
    cmp_vld_d = cmp_vld_q;
    err_d     = err_q;
    ff_vld_d  = ff_vld_q;
    ff_vec_d  = ff_vec_q;
    // start is only registered while idle/done, so pulses during a run vanish
    start_d   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    if (cmp_vld_q && mismatch) begin
      err_d = err_q + 1'b1;
      if (!ff_vld_q) begin
        ff_vld_d = 1'b1;
        ff_vec_d = vec_q;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_q) begin
          state_d   = ST_RUN;
          idx_d     = '0;
          vec_d     = '0;
          cmp_vld_d = 1'b0;
          err_d     = '0;
          ff_vld_d  = 1'b0;
          ff_vec_d  = '0;
        end
      end
      ST_RUN: begin
        vec_d     = vec_t'(idx_q);
        cmp_vld_d = 1'b1;
        idx_d     = idx_q + 1'b1;
        if (idx_q == IDX_W'(NUM_VEC - 1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cmp_vld_d = 1'b0;
        state_d   = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      idx_q     <= '0;
      vec_q     <= '0;
      cmp_vld_q <= 1'b0;
      err_q     <= '0;
      ff_vld_q  <= 1'b0;
      ff_vec_q  <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      idx_q     <= idx_d;
      vec_q     <= vec_d;
      cmp_vld_q <= cmp_vld_d;
      err_q     <= err_d;
      ff_vld_q  <= ff_vld_d;
      ff_vec_q  <= ff_vec_d;
    end
  end

  assign a_o            = vec_q.a;
  assign b_o            = vec_q.b;
  assign sel_o          = vec_q.sel;
  assign busy           = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done           = (state_q == ST_DONE);
  assign pass           = (state_q == ST_DONE) && (err_q == '0);
  assign err_count      = err_q;
  assign first_fail_vld = ff_vld_q;
  assign first_fail_vec = ff_vec_q;

endmodule
